dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory (dmem) between the core load/store path (port 0) and a debug/program-loader port (port 1). Accepts one request at a time via valid/ready and sequences it onto dmem's addr/wr_data/mem_wr/mem_rd/mask interface. Waits a fixed read latency, then returns a one-cycle response to the requester. Also drives a stall to the core's PC/control while a port-0 request is pending or in flight.

Parameters:
LAT, 1, dmem read latency in cycles from mem_rd assertion to valid mem_rdata; legal range 1..4.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
req0_valid  in  1  core request valid
req0_ready  out  1  core request accepted this cycle
req0_addr  in  ADDR_W  core byte address
req0_wdata  in  32  core store data
req0_we  in  1  1=store, 0=load
req0_mask  in  3  access size/sign code, passed through to dmem
rsp0_valid  out  1  core response pulse
rsp0_data  out  32  core load data (0 for stores)
req1_valid, req1_ready, req1_addr, req1_wdata, req1_we, req1_mask, rsp1_valid, rsp1_data  same widths/meanings for port 1
mem_addr  out  ADDR_W  to dmem addr
mem_wr_data  out  32  to dmem wr_data
mem_wr  out  1  dmem write strobe
mem_rd  out  1  dmem read strobe
mem_mask  out  3  to dmem mask
mem_rdata  in  32  from dmem dmem_o
stall_o  out  1  core stall

Behaviour:
- Reset (rst==0 at edge): state=IDLE, last_grant=1, cnt=0; req*_ready=0, rsp*_valid=0, rsp*_data=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_wr_data=0, mem_mask=0. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req valid, grant and go to ISSUE; otherwise stay. req*_ready is combinational, asserted only in IDLE for the granted port, for exactly one cycle. The granted port's addr/wdata/we/mask and the grant id are captured at that edge.
- Arbitration:
  - A single valid port wins.
  - If both are valid, the port != last_grant wins. last_grant is updated on each grant.
  - After reset, port 0 wins the first tie.
- ISSUE (1 cycle):
  - Drive captured addr/wdata/mask on mem_*.
  - mem_wr=we and mem_rd=!we; both strobes are 0 in every other state.
  - Store -> RESP. Load -> WAIT with cnt=LAT-1.
- WAIT: lasts exactly LAT cycles. mem_rdata is sampled on the last WAIT cycle (cnt==0), then -> RESP; otherwise cnt decrements.
- RESP (1 cycle):
  - rsp<g>_valid=1 for the granted port only.
  - rsp<g>_data holds the loaded data, or 0 for a store. It is held until that port's next response.
  - Next state is IDLE.
- mem_addr, mem_wr_data and mem_mask hold their last values outside ISSUE.
- Timing: ISSUE at cycle t.
  - Store: response at t+1, 3 cycles from accept to IDLE.
  - Load: response at t+LAT+1.
- Requester rules:
  - Requester valid must not depend on ready.
  - A requester keeps valid and payload stable until ready.
  - Requests arriving outside IDLE are held off (ready=0), never dropped.
- stall_o = (req0_valid && !req0_ready) || (grant==0 && state!=IDLE).
- rsp0_valid and rsp1_valid are never asserted in the same cycle.

Test Plan:
- Reset: hold rst=0 5 cycles with both valids high -> all outputs 0, no ready; release -> port 0 ready in first IDLE cycle.
- Port-0 store, addr=0x10, wdata=0xDEADBEEF, mask=3'b010 -> ISSUE has mem_wr=1, mem_rd=0, mem_addr=0x10; rsp0_valid one cycle later with rsp0_data=0.
- Port-1 load, addr=0x10, LAT=2, mem_rdata=0xDEADBEEF -> mem_rd one cycle; rsp1_valid exactly 3 cycles after ISSUE with rsp1_data=0xDEADBEEF; rsp0_valid stays 0.
- Both valid continuously for 4 transactions -> grants alternate 0,1,0,1; each ready is a single-cycle pulse; stall_o is high whenever port 0 is waiting or in flight.
- Port-0 request arrives during a port-1 WAIT -> req0_ready=0 and stall_o=1 until IDLE; then port 0 is granted with its held payload intact.
- Assert rst=0 during a WAIT -> next cycle state is IDLE, mem_rd=0, and no rsp_valid pulse ever appears for the aborted load.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles requester ports, dmem side and core stall for the dmem arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request ports; responses are unthrottled pulses.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;
    logic              req0_we;
    logic [2:0]        req0_mask;
    logic              rsp0_valid;
    logic [31:0]       rsp0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;
    logic              req1_we;
    logic [2:0]        req1_mask;
    logic              rsp1_valid;
    logic [31:0]       rsp1_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr;
    logic              mem_rd;
    logic [2:0]        mem_mask;
    logic [31:0]       mem_rdata;

    logic              stall_o;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_we, req0_mask,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr, req1_wdata, req1_we, req1_mask,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_addr, mem_wr_data, mem_wr, mem_rd, mem_mask,
        input  mem_rdata,
        output stall_o
    );

    // Requester / memory side
    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_we, req0_mask,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr, req1_wdata, req1_we, req1_mask,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_addr, mem_wr_data, mem_wr, mem_rd, mem_mask,
        output mem_rdata,
        input  stall_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one dmem between the core (port 0) and debug/loader (port 1), one access at a time.
// Latency: store responds 1 cycle after ISSUE, load LAT+1 cycles after ISSUE.
// Backpressure: ready only in IDLE for the granted port; others held off, never dropped.
module dmem_arbiter #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        mask_q, mask_d;
    logic [31:0]       rsp0_data_q, rsp0_data_d;
    logic [31:0]       rsp1_data_q, rsp1_data_d;

    logic              win1;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic              mem_wr, mem_rd;

    // Next-state, grant/capture and strobe decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        // On a tie the port that did not win last time goes next
        win1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

        case (state_q)
            IDLE: begin
                // rst gates ready so nothing looks accepted while reset is held
                if (rst && (bus.req0_valid || bus.req1_valid)) begin
                    grant_d      = win1;
                    last_grant_d = win1;
                    state_d      = ISSUE;
                    if (win1) begin
                        req1_ready = 1'b1;
                        we_d       = bus.req1_we;
                        addr_d     = bus.req1_addr;
                        wdata_d    = bus.req1_wdata;
                        mask_d     = bus.req1_mask;
                    end else begin
                        req0_ready = 1'b1;
                        we_d       = bus.req0_we;
                        addr_d     = bus.req0_addr;
                        wdata_d    = bus.req0_wdata;
                        mask_d     = bus.req0_mask;
                    end
                end
            end
            ISSUE: begin
                mem_wr = we_q;
                mem_rd = !we_q;
                if (we_q) begin
                    // Stores return zero data on the response
                    state_d = RESP;
                    if (grant_q) rsp1_data_d = '0;
                    else         rsp0_data_d = '0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    if (grant_q) rsp1_data_d = bus.mem_rdata;
                    else         rsp0_data_d = bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                rsp0_valid = !grant_q;
                rsp1_valid = grant_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    // Captured payload doubles as the dmem bus, so it holds outside ISSUE
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_mask    = mask_q;
    assign bus.mem_wr      = mem_wr;
    assign bus.mem_rd      = mem_rd;
    assign bus.req0_ready  = req0_ready;
    assign bus.req1_ready  = req1_ready;
    assign bus.rsp0_valid  = rsp0_valid;
    assign bus.rsp1_valid  = rsp1_valid;
    assign bus.rsp0_data   = rsp0_data_q;
    assign bus.rsp1_data   = rsp1_data_q;
    // Core stalls while its request waits for a grant or its access is in flight
    assign bus.stall_o     = rst && ((bus.req0_valid && !req0_ready) ||
                                     (!grant_q && state_q != IDLE));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with LAT=2: per-cycle vector table plus corner sequences.
// Latency: checks store at ISSUE+1 and load at ISSUE+3 responses.
// Backpressure: exercises held-off requests and mid-transaction reset.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(.LAT(2), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst, v0, v1, we0, we1;
        logic [31:0] rdata;
        logic        rdy0, rdy1, mwr, mrd, rv0, rv1, stall;
        logic [31:0] maddr, rsp0d, rsp1d;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    initial begin
        int got, waited, resp_at, pulses;

        // rst, v0,v1,we0,we1, rdata,  rdy0,rdy1,mwr,mrd,rv0,rv1,stall, maddr, rsp0d, rsp1d
        tbl[0]  = '{0,1,1,1,0, 32'h0,        0,0,0,0,0,0,0, 32'h00, 32'h0, 32'h0};
        tbl[1]  = '{0,1,1,1,0, 32'h0,        0,0,0,0,0,0,0, 32'h00, 32'h0, 32'h0};
        tbl[2]  = '{1,1,1,1,0, 32'h0,        1,0,0,0,0,0,0, 32'h00, 32'h0, 32'h0};
        tbl[3]  = '{1,1,1,0,0, 32'h0,        0,0,1,0,0,0,1, 32'h10, 32'h0, 32'h0};
        tbl[4]  = '{1,1,1,0,0, 32'h0,        0,0,0,0,1,0,1, 32'h10, 32'h0, 32'h0};
        tbl[5]  = '{1,1,1,0,0, 32'h0,        0,1,0,0,0,0,1, 32'h10, 32'h0, 32'h0};
        tbl[6]  = '{1,1,1,0,0, 32'h0,        0,0,0,1,0,0,1, 32'h24, 32'h0, 32'h0};
        tbl[7]  = '{1,1,1,0,0, 32'h0,        0,0,0,0,0,0,1, 32'h24, 32'h0, 32'h0};
        tbl[8]  = '{1,1,1,0,0, 32'hCAFEF00D, 0,0,0,0,0,0,1, 32'h24, 32'h0, 32'h0};
        tbl[9]  = '{1,1,1,0,0, 32'h0,        0,0,0,0,0,1,1, 32'h24, 32'h0, 32'hCAFEF00D};
        tbl[10] = '{1,1,1,0,0, 32'h0,        1,0,0,0,0,0,0, 32'h24, 32'h0, 32'hCAFEF00D};
        tbl[11] = '{1,1,1,1,0, 32'h0,        0,0,0,1,0,0,1, 32'h10, 32'h0, 32'hCAFEF00D};
        tbl[12] = '{1,1,1,1,0, 32'h0,        0,0,0,0,0,0,1, 32'h10, 32'h0, 32'hCAFEF00D};
        tbl[13] = '{1,1,1,1,0, 32'h11112222, 0,0,0,0,0,0,1, 32'h10, 32'h0, 32'hCAFEF00D};
        tbl[14] = '{1,1,1,1,0, 32'h0,        0,0,0,0,1,0,1, 32'h10, 32'h11112222, 32'hCAFEF00D};
        tbl[15] = '{1,1,1,1,0, 32'h0,        0,1,0,0,0,0,1, 32'h10, 32'h11112222, 32'hCAFEF00D};
        tbl[16] = '{1,1,0,1,0, 32'h0,        0,0,0,1,0,0,1, 32'h24, 32'h11112222, 32'hCAFEF00D};
        tbl[17] = '{1,1,0,1,0, 32'h0,        0,0,0,0,0,0,1, 32'h24, 32'h11112222, 32'hCAFEF00D};
        tbl[18] = '{1,1,0,1,0, 32'h0BADF00D, 0,0,0,0,0,0,1, 32'h24, 32'h11112222, 32'hCAFEF00D};
        tbl[19] = '{1,1,0,1,0, 32'h0,        0,0,0,0,0,1,1, 32'h24, 32'h11112222, 32'h0BADF00D};
        tbl[20] = '{1,1,0,1,0, 32'h0,        1,0,0,0,0,0,0, 32'h24, 32'h11112222, 32'h0BADF00D};
        tbl[21] = '{1,0,0,1,0, 32'h0,        0,0,1,0,0,0,1, 32'h10, 32'h11112222, 32'h0BADF00D};
        tbl[22] = '{1,0,0,1,0, 32'h0,        0,0,0,0,1,0,1, 32'h10, 32'h0, 32'h0BADF00D};
        tbl[23] = '{1,0,0,1,0, 32'h0,        0,0,0,0,0,0,0, 32'h10, 32'h0, 32'h0BADF00D};

        rst            = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 32'h10;
        bus.req0_wdata = 32'hDEADBEEF;
        bus.req0_we    = 1'b1;
        bus.req0_mask  = 3'b010;
        bus.req1_addr  = 32'h24;
        bus.req1_wdata = 32'h12345678;
        bus.req1_we    = 1'b0;
        bus.req1_mask  = 3'b101;
        bus.mem_rdata  = 32'h0;

        // Reset held with both valids high: dmem-side outputs at zero
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wdata", bus.mem_wr_data, 32'h0);
        chk("rst_mask", 32'(bus.mem_mask), 32'h0);

        // Table: one row per cycle, inputs before compare, outputs reflect pre-edge state
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            rst            = tbl[i].rst;
            bus.req0_valid = tbl[i].v0;
            bus.req1_valid = tbl[i].v1;
            bus.req0_we    = tbl[i].we0;
            bus.req1_we    = tbl[i].we1;
            bus.mem_rdata  = tbl[i].rdata;
            #1;
            chk($sformatf("r%0d_rdy0", i), 32'(bus.req0_ready), 32'(tbl[i].rdy0));
            chk($sformatf("r%0d_rdy1", i), 32'(bus.req1_ready), 32'(tbl[i].rdy1));
            chk($sformatf("r%0d_mwr", i), 32'(bus.mem_wr), 32'(tbl[i].mwr));
            chk($sformatf("r%0d_mrd", i), 32'(bus.mem_rd), 32'(tbl[i].mrd));
            chk($sformatf("r%0d_rv0", i), 32'(bus.rsp0_valid), 32'(tbl[i].rv0));
            chk($sformatf("r%0d_rv1", i), 32'(bus.rsp1_valid), 32'(tbl[i].rv1));
            chk($sformatf("r%0d_stall", i), 32'(bus.stall_o), 32'(tbl[i].stall));
            chk($sformatf("r%0d_maddr", i), bus.mem_addr, tbl[i].maddr);
            chk($sformatf("r%0d_rsp0d", i), bus.rsp0_data, tbl[i].rsp0d);
            chk($sformatf("r%0d_rsp1d", i), bus.rsp1_data, tbl[i].rsp1d);
        end

        // Port-1 load of 0x10; port 0 raises a store during WAIT and must be held off
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 32'h10;
        bus.mem_rdata  = 32'hDEADBEEF;
        #1;
        chk("b_rdy1", 32'(bus.req1_ready), 32'h1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        chk("b_issue_mrd", 32'(bus.mem_rd), 32'h1);
        chk("b_issue_addr", bus.mem_addr, 32'h10);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b1;
        bus.req0_addr  = 32'h40;
        bus.req0_wdata = 32'hA5A5A5A5;
        bus.req0_mask  = 3'b001;
        #1;
        chk("b_wait_rdy0", 32'(bus.req0_ready), 32'h0);
        chk("b_wait_stall", 32'(bus.stall_o), 32'h1);
        chk("b_wait_mrd", 32'(bus.mem_rd), 32'h0);
        got = 0; waited = -1; resp_at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bus.req0_ready) begin
                got = 1;
                waited = k;
                break;
            end
            chk($sformatf("b_hold_stall%0d", k), 32'(bus.stall_o), 32'h1);
            chk($sformatf("b_hold_rv0_%0d", k), 32'(bus.rsp0_valid), 32'h0);
            if (bus.rsp1_valid) begin
                resp_at = k;
                chk("b_rsp1_data", bus.rsp1_data, 32'hDEADBEEF);
            end
        end
        chk("b_ready_seen", 32'(got), 32'h1);
        chk("b_ready_cycle", 32'(waited), 32'h2);
        chk("b_rsp1_cycle", 32'(resp_at), 32'h1);
        chk("b_grant_stall", 32'(bus.stall_o), 32'h0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("b_iss_wr", 32'(bus.mem_wr), 32'h1);
        chk("b_iss_rd", 32'(bus.mem_rd), 32'h0);
        chk("b_iss_addr", bus.mem_addr, 32'h40);
        chk("b_iss_wdata", bus.mem_wr_data, 32'hA5A5A5A5);
        chk("b_iss_mask", 32'(bus.mem_mask), 32'h1);
        @(negedge clk);
        #1;
        chk("b_rsp0_v", 32'(bus.rsp0_valid), 32'h1);
        chk("b_rsp0_d", bus.rsp0_data, 32'h0);

        // Reset lands during a port-1 WAIT: load is abandoned without a response
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 32'h80;
        bus.mem_rdata  = 32'h55AA55AA;
        #1;
        chk("c_rdy1", 32'(bus.req1_ready), 32'h1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        chk("c_issue_mrd", 32'(bus.mem_rd), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b1;
        bus.req0_addr  = 32'h44;
        #1;
        chk("c_after_mrd", 32'(bus.mem_rd), 32'h0);
        chk("c_after_rv1", 32'(bus.rsp1_valid), 32'h0);
        chk("c_idle_rdy0", 32'(bus.req0_ready), 32'h1);
        chk("c_rsp1d_clr", bus.rsp1_data, 32'h0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
            #1;
            if (bus.rsp1_valid) pulses++;
        end
        chk("c_no_rsp1", 32'(pulses), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
